if_fetch: RTL and testbench

Instruction-fetch stage of the five-stage pipeline, sitting directly downstream of the PC register and upstream of the IF/ID register. Each cycle it takes the PC and chip-enable from the PC stage and issues an in-order request to instruction memory using a grant/rvalid handshake. It buffers returned words with their PCs in a small queue for the decode stage and raises a stall request to the stall controller whenever it cannot accept the current PC. On branch or interrupt it flushes the queue and discards responses still in flight.

---
 rtl/if_fetch_pkg.sv | 23 ++
 rtl/if_fetch_fifo.sv | 59 +++++
 rtl/if_fetch.sv | 102 ++++++++++
 tb/tb_if_fetch.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_pkg.sv
// Shared fetch-stage types and bus constants.
package if_fetch_pkg;

  localparam int unsigned INST_ADDR_BUS = 32;
  localparam int unsigned INST_BUS      = 32;

  localparam logic [INST_BUS-1:0] NOP_WORD_DEF = 32'h0000_0000;

  localparam logic STALL_ENABLE  = 1'b1;
  localparam logic STALL_DISABLE = 1'b0;

  // One buffered fetch result handed to decode
  typedef struct packed {
    logic [INST_ADDR_BUS-1:0] pc;
    logic [INST_BUS-1:0]      inst;
  } fetch_entry_t;

  // Occupancy counters must represent 0..depth inclusive
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/if_fetch_fifo.sv
// Small synchronous FIFO with clear and occupancy count; depth is a power of two.
module fetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  // Never write into a full FIFO nor read an empty one; clear wins over both
  assign w_push = push_i & ~clr_i & (r_count != CW'(DEPTH));
  assign w_pop  = pop_i  & ~clr_i & (r_count != CW'(0));

  // Pointer and occupancy bookkeeping; pointers wrap naturally mod DEPTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clr_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; contents are only observed through a valid count
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wdata_i;
  end

  assign rdata_o = r_mem[r_rd_ptr];
  assign count_o = r_count;

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: in-order imem requests with credit, tag tracking,
// output queue for decode, and flush-time discard of in-flight responses.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int unsigned          DEPTH    = 2,
  parameter logic [INST_BUS-1:0]  NOP_WORD = NOP_WORD_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [INST_ADDR_BUS-1:0]  pc_i,
  input  logic                      ce_i,
  input  logic                      flush_i,
  input  logic                      stall_i,
  output logic                      stall_req_o,
  output logic                      imem_req_o,
  output logic [INST_ADDR_BUS-1:0]  imem_addr_o,
  input  logic                      imem_gnt_i,
  input  logic                      imem_rvalid_i,
  input  logic [INST_BUS-1:0]       imem_rdata_i,
  output logic                      id_valid_o,
  output logic [INST_ADDR_BUS-1:0]  id_pc_o,
  output logic [INST_BUS-1:0]       id_inst_o
);

  localparam int unsigned CW = cnt_width(DEPTH);
  localparam int unsigned SW = CW + 1;
  localparam int unsigned EW = $bits(fetch_entry_t);

  logic [CW-1:0]            w_out_cnt;
  logic [CW-1:0]            w_buf_cnt;
  logic [CW-1:0]            r_disc_cnt;
  logic [SW-1:0]            w_committed;
  logic                     w_credit_ok;
  logic                     w_accept;
  logic                     w_rsp;
  logic                     w_drop;
  logic                     w_buf_push;
  logic                     w_buf_pop;
  logic [INST_ADDR_BUS-1:0] w_tag;
  fetch_entry_t             w_new_entry;
  fetch_entry_t             w_head;
  logic [EW-1:0]            w_head_raw;

  // Credit from registered state only: live in-flight plus buffered must leave a slot
  assign w_committed = SW'(w_out_cnt) - SW'(r_disc_cnt) + SW'(w_buf_cnt);
  assign w_credit_ok = (w_out_cnt < CW'(DEPTH)) && (w_committed < SW'(DEPTH));

  assign imem_req_o  = ce_i & w_credit_ok & ~flush_i;
  assign imem_addr_o = pc_i;
  assign w_accept    = imem_req_o & imem_gnt_i;
  assign stall_req_o = (ce_i & ~w_accept) ? STALL_ENABLE : STALL_DISABLE;

  // A response with nothing outstanding is a protocol error and is ignored
  assign w_rsp       = imem_rvalid_i & (w_out_cnt != CW'(0));
  assign w_drop      = flush_i | (r_disc_cnt != CW'(0));
  assign w_buf_push  = w_rsp & ~w_drop;
  assign w_buf_pop   = id_valid_o & ~stall_i;

  assign w_new_entry = '{pc: w_tag, inst: imem_rdata_i};
  assign w_head      = fetch_entry_t'(w_head_raw);

  // Tag FIFO: PCs of granted requests awaiting their response; also the outstanding count
  fetch_fifo #(.WIDTH(INST_ADDR_BUS), .DEPTH(DEPTH)) u_tag_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .clr_i   (1'b0),
    .push_i  (w_accept),
    .pop_i   (w_rsp),
    .wdata_i (pc_i),
    .rdata_o (w_tag),
    .count_o (w_out_cnt)
  );

  // Output queue towards decode; flush clears it and overrides any pop
  fetch_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_out_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .clr_i   (flush_i),
    .push_i  (w_buf_push),
    .pop_i   (w_buf_pop),
    .wdata_i (w_new_entry),
    .rdata_o (w_head_raw),
    .count_o (w_buf_cnt)
  );

  // Discard counter: on flush every still-unanswered request becomes a drop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_disc_cnt <= '0;
    end else if (flush_i) begin
      r_disc_cnt <= w_out_cnt - CW'(w_rsp);
    end else if (w_rsp && (r_disc_cnt != CW'(0))) begin
      r_disc_cnt <= r_disc_cnt - CW'(1);
    end
  end

  assign id_valid_o = (w_buf_cnt != CW'(0));
  assign id_pc_o    = id_valid_o ? w_head.pc   : '0;
  assign id_inst_o  = id_valid_o ? w_head.inst : NOP_WORD;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed vector table, queue-based random reference, reset corner.
module tb_if_fetch;

  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        ce, flush, stall, gnt, rvalid;
  logic [31:0] rdata;
  logic        stall_req, imem_req, id_valid;
  logic [31:0] imem_addr, id_pc, id_inst;

  int n_vec = 0;
  int n_bad = 0;

  if_fetch #(.DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_i          (pc),
    .ce_i          (ce),
    .flush_i       (flush),
    .stall_i       (stall),
    .stall_req_o   (stall_req),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_gnt_i    (gnt),
    .imem_rvalid_i (rvalid),
    .imem_rdata_i  (rdata),
    .id_valid_o    (id_valid),
    .id_pc_o       (id_pc),
    .id_inst_o     (id_inst)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ce;
    logic [31:0] pc;
    logic        flush, stall, gnt, rv;
    logic [31:0] rdata;
    logic        e_req, e_stall, e_valid;
    logic [31:0] e_pc, e_inst;
  } vec_t;

  vec_t tbl[$];

  // Reference: PCs awaiting response, pending drops, and buffered {pc,inst} pairs
  logic [31:0] m_tags[$];
  logic [63:0] m_buf[$];
  int          m_disc;

  function automatic vec_t mk(logic c, logic [31:0] p, logic f, logic s, logic g, logic r,
                              logic [31:0] d, logic er, logic es, logic ev,
                              logic [31:0] ep, logic [31:0] ei);
    vec_t v;
    v.ce = c; v.pc = p; v.flush = f; v.stall = s; v.gnt = g; v.rv = r; v.rdata = d;
    v.e_req = er; v.e_stall = es; v.e_valid = ev; v.e_pc = ep; v.e_inst = ei;
    return v;
  endfunction

  task automatic drive(input logic c, input logic [31:0] p, input logic f, input logic s,
                       input logic g, input logic r, input logic [31:0] d);
    @(negedge clk);
    ce = c; pc = p; flush = f; stall = s; gnt = g; rvalid = r; rdata = d;
    #1;
  endtask

  task automatic check(input string name, input logic er, input logic es, input logic ev,
                       input logic [31:0] ea, input logic [31:0] ep, input logic [31:0] ei);
    n_vec++;
    if ({imem_req, stall_req, id_valid, imem_addr, id_pc, id_inst} !== {er, es, ev, ea, ep, ei}) begin
      n_bad++;
      $display("FAIL %s: got req=%b stall=%b valid=%b addr=%h pc=%h inst=%h, want req=%b stall=%b valid=%b addr=%h pc=%h inst=%h",
               name, imem_req, stall_req, id_valid, imem_addr, id_pc, id_inst, er, es, ev, ea, ep, ei);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    ce = 0; pc = 0; flush = 0; stall = 0; gnt = 0; rvalid = 0; rdata = 0;
    @(negedge clk);
    rst = 1'b1;
    m_tags.delete(); m_buf.delete(); m_disc = 0;
  endtask

  // Expected outputs from the reference state and the inputs of this cycle
  task automatic m_expect(output logic er, output logic es, output logic ev,
                          output logic [31:0] ep, output logic [31:0] ei);
    int  outstanding = m_tags.size();
    int  live        = outstanding - m_disc;
    bit  credit      = (outstanding < DEPTH) && (live + m_buf.size() < DEPTH);
    er = ce && credit && !flush;
    es = ce && !(er && gnt);
    ev = (m_buf.size() != 0);
    ep = ev ? m_buf[0][63:32] : 32'h0;
    ei = ev ? m_buf[0][31:0]  : NOP;
  endtask

  // Advance the reference by one clock edge
  task automatic m_step(input logic acc);
    logic [31:0] t;
    if (m_buf.size() != 0 && !stall && !flush) void'(m_buf.pop_front());
    if (rvalid && m_tags.size() != 0) begin
      t = m_tags.pop_front();
      if (flush)           ;
      else if (m_disc > 0) m_disc--;
      else                 m_buf.push_back({t, rdata});
    end
    if (flush) begin
      m_buf.delete();
      m_disc = m_tags.size();
    end
    if (acc) m_tags.push_back(pc);
  endtask

  initial begin
    logic        er, es, ev;
    logic [31:0] ep, ei;
    logic [31:0] rpc;

    rst = 1'b0;
    ce = 0; pc = 0; flush = 0; stall = 0; gnt = 0; rvalid = 0; rdata = 0;
    m_disc = 0;
    #3;
    check("in_reset", 0, 0, 0, 32'h0, 32'h0, NOP);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Basic fetch, single-cycle memory
    tbl.push_back(mk(0, 32'h0,         0,0,0,0, 32'h0,          0,0,0, 32'h0, NOP));
    tbl.push_back(mk(1, 32'hBFC0_0000, 0,0,1,0, 32'h0,          1,0,0, 32'h0, NOP));
    tbl.push_back(mk(1, 32'hBFC0_0004, 0,0,1,1, 32'h2401_0005,  1,0,0, 32'h0, NOP));
    tbl.push_back(mk(0, 32'h0,         0,0,0,1, 32'h2402_0006,  0,0,1, 32'hBFC0_0000, 32'h2401_0005));
    tbl.push_back(mk(0, 32'h0,         0,0,0,0, 32'h0,          0,0,1, 32'hBFC0_0004, 32'h2402_0006));
    tbl.push_back(mk(0, 32'h0,         0,0,0,0, 32'h0,          0,0,0, 32'h0, NOP));
    // Decode stalled: two grants fill the queue, then credit runs out
    tbl.push_back(mk(1, 32'h0,         0,1,1,0, 32'h0,          1,0,0, 32'h0, NOP));
    tbl.push_back(mk(1, 32'h4,         0,1,1,1, 32'h1111_0000,  1,0,0, 32'h0, NOP));
    tbl.push_back(mk(1, 32'h8,         0,1,1,1, 32'h1111_0004,  0,1,1, 32'h0, 32'h1111_0000));
    tbl.push_back(mk(1, 32'h8,         0,1,1,0, 32'h0,          0,1,1, 32'h0, 32'h1111_0000));
    tbl.push_back(mk(1, 32'h8,         0,0,1,0, 32'h0,          0,1,1, 32'h0, 32'h1111_0000));
    tbl.push_back(mk(1, 32'h8,         0,0,1,0, 32'h0,          1,0,1, 32'h4, 32'h1111_0004));
    tbl.push_back(mk(0, 32'h0,         0,0,0,1, 32'h1111_0008,  0,0,0, 32'h0, NOP));
    tbl.push_back(mk(0, 32'h0,         0,0,0,0, 32'h0,          0,0,1, 32'h8, 32'h1111_0008));
    tbl.push_back(mk(0, 32'h0,         0,0,0,0, 32'h0,          0,0,0, 32'h0, NOP));
    // Flush with two in flight; both responses dropped, branch target delivered
    tbl.push_back(mk(1, 32'h40,        0,0,1,0, 32'h0,          1,0,0, 32'h0, NOP));
    tbl.push_back(mk(1, 32'h44,        0,0,1,0, 32'h0,          1,0,0, 32'h0, NOP));
    tbl.push_back(mk(1, 32'h48,        1,0,1,0, 32'h0,          0,1,0, 32'h0, NOP));
    tbl.push_back(mk(1, 32'h100,       0,0,1,1, 32'hDEAD_0001,  0,1,0, 32'h0, NOP));
    tbl.push_back(mk(1, 32'h100,       0,0,1,1, 32'hDEAD_0002,  1,0,0, 32'h0, NOP));
    tbl.push_back(mk(0, 32'h0,         0,0,0,1, 32'h0800_0040,  0,0,0, 32'h0, NOP));
    tbl.push_back(mk(0, 32'h0,         0,0,0,0, 32'h0,          0,0,1, 32'h100, 32'h0800_0040));
    tbl.push_back(mk(0, 32'h0,         0,0,0,0, 32'h0,          0,0,0, 32'h0, NOP));
    // Flush coinciding with a response and an offered request
    tbl.push_back(mk(1, 32'h200,       0,0,1,0, 32'h0,          1,0,0, 32'h0, NOP));
    tbl.push_back(mk(1, 32'h204,       0,0,1,0, 32'h0,          1,0,0, 32'h0, NOP));
    tbl.push_back(mk(1, 32'h300,       1,0,1,1, 32'h0000_BAD0,  0,1,0, 32'h0, NOP));
    tbl.push_back(mk(1, 32'h300,       0,0,1,1, 32'h0000_BAD1,  1,0,0, 32'h0, NOP));
    tbl.push_back(mk(0, 32'h0,         0,0,0,1, 32'h0000_3333,  0,0,0, 32'h0, NOP));
    tbl.push_back(mk(0, 32'h0,         0,0,0,0, 32'h0,          0,0,1, 32'h300, 32'h0000_3333));
    // Grant withheld for three cycles
    tbl.push_back(mk(1, 32'h500,       0,0,0,0, 32'h0,          1,1,0, 32'h0, NOP));
    tbl.push_back(mk(1, 32'h500,       0,0,0,0, 32'h0,          1,1,0, 32'h0, NOP));
    tbl.push_back(mk(1, 32'h500,       0,0,0,0, 32'h0,          1,1,0, 32'h0, NOP));
    tbl.push_back(mk(1, 32'h500,       0,0,1,0, 32'h0,          1,0,0, 32'h0, NOP));
    tbl.push_back(mk(0, 32'h0,         0,0,0,1, 32'h0000_5555,  0,0,0, 32'h0, NOP));
    tbl.push_back(mk(0, 32'h0,         0,0,0,0, 32'h0,          0,0,1, 32'h500, 32'h0000_5555));
    tbl.push_back(mk(1, 32'h600,       0,0,1,0, 32'h0,          1,0,0, 32'h0, NOP));
    tbl.push_back(mk(0, 32'h0,         0,0,0,1, 32'h0000_6666,  0,0,0, 32'h0, NOP));
    tbl.push_back(mk(0, 32'h0,         0,0,0,0, 32'h0,          0,0,1, 32'h600, 32'h0000_6666));
    // Response with nothing outstanding is ignored
    tbl.push_back(mk(0, 32'h0,         0,0,0,1, 32'h0000_7777,  0,0,0, 32'h0, NOP));
    tbl.push_back(mk(0, 32'h0,         0,0,0,0, 32'h0,          0,0,0, 32'h0, NOP));
    tbl.push_back(mk(1, 32'h700,       0,0,1,0, 32'h0,          1,0,0, 32'h0, NOP));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].ce, tbl[i].pc, tbl[i].flush, tbl[i].stall, tbl[i].gnt, tbl[i].rv, tbl[i].rdata);
      check($sformatf("tbl[%0d]", i), tbl[i].e_req, tbl[i].e_stall, tbl[i].e_valid,
            tbl[i].pc, tbl[i].e_pc, tbl[i].e_inst);
    end

    // Randomised traffic against the queue reference
    do_reset();
    rpc = 32'hBFC0_0000;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic r_ce, r_fl, r_st, r_g, r_rv;
      r_ce = ($urandom_range(0, 9) < 8);
      r_fl = ($urandom_range(0, 19) == 0);
      r_st = ($urandom_range(0, 9) < 3);
      r_g  = ($urandom_range(0, 9) < 7);
      r_rv = (m_tags.size() != 0) ? ($urandom_range(0, 9) < 5) : ($urandom_range(0, 19) == 0);
      drive(r_ce, rpc, r_fl, r_st, r_g, r_rv, $urandom);
      m_expect(er, es, ev, ep, ei);
      check($sformatf("rnd[%0d]", cyc), er, es, ev, rpc, ep, ei);
      m_step(er && gnt);
      if (r_fl)            rpc = $urandom & 32'hFFFF_FFFC;
      else if (er && gnt)  rpc = rpc + 32'd4;
    end

    // Asynchronous reset mid-burst with two requests outstanding
    do_reset();
    drive(1, 32'h10, 0,0,1,0, 32'h0);
    check("rst_g0", 1, 0, 0, 32'h10, 32'h0, NOP);
    drive(1, 32'h14, 0,0,1,0, 32'h0);
    check("rst_g1", 1, 0, 0, 32'h14, 32'h0, NOP);
    drive(1, 32'h18, 0,0,1,0, 32'h0);
    check("rst_full", 0, 1, 0, 32'h18, 32'h0, NOP);
    #2 rst = 1'b0;
    #1;
    check("rst_async", 1, 0, 0, 32'h18, 32'h0, NOP);
    drive(0, 32'h0, 0,0,0,0, 32'h0);
    check("rst_held", 0, 0, 0, 32'h0, 32'h0, NOP);
    rst = 1'b1;
    drive(0, 32'h0, 0,0,0,1, 32'hBEEF_0000);
    check("rst_stray", 0, 0, 0, 32'h0, 32'h0, NOP);
    drive(1, 32'h20, 0,0,1,0, 32'h0);
    check("rst_after_stray", 1, 0, 0, 32'h20, 32'h0, NOP);
    drive(0, 32'h0, 0,0,0,1, 32'h2020_2020);
    check("rst_fresh_rsp", 0, 0, 0, 32'h0, 32'h0, NOP);
    drive(0, 32'h0, 0,0,0,0, 32'h0);
    check("rst_fresh_out", 0, 0, 1, 32'h0, 32'h20, 32'h2020_2020);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
